window_controller: RTL and testbench
====================================

Name: window_controller

Overview:
- Stage directly downstream of the 128-pixel line buffering. Accepts the raster pixel stream and stores it round-robin in four internal line memories.
- Once three full lines are held, emits 3x3 pixel windows (72 bits) to the convolution stage over a valid/ready handshake.
- Pulses an interrupt after each output row so the DMA/driver can refill.

Parameters:
- IMG_W, 128, pixels per image line; legal range 4..1024. Each line memory is IMG_W x 8 bits.
- CNT_W, $clog2(4*IMG_W+1), width of the stored-pixel counter; derived, never overridden.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  incoming pixel.
- in_valid_data  in  1  in_data valid this cycle.
- in_ready  out  1  block can accept a pixel; a write occurs when in_valid_data && in_ready.
- out_window  out  72  3x3 window.
- out_valid  out  1  out_window holds an untransferred window.
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready.
- intr  out  1  one-cycle pulse per completed output row.

Behaviour:
- Reset (reset=0, async) clears the following; line memory contents are not reset:
  - wr_col, wr_sel, rd_col, rd_sel and pix_count all go to 0.
  - state goes to IDLE.
  - out_valid=0, out_window=0, intr=0.
  - in_ready=1 during and after reset.
- Write side:
  - On each accepted pixel, mem[wr_sel][wr_col] <= in_data.
  - wr_col increments. At IMG_W-1 it wraps to 0 and wr_sel increments mod 4.
- in_ready = (pix_count != 4*IMG_W), combinational. A pixel offered while in_ready=0 is dropped, with no state change.
- pix_count = pixels stored but not yet retired:
  - +1 per accepted write.
  - -IMG_W per row retire.
  - Both in the same cycle: count + 1 - IMG_W.
- Read FSM, two states:
  - IDLE -> READ when pix_count >= 3*IMG_W. rd_col=0.
  - In READ, a load happens when (!out_valid || out_ready):
    - out_window <= window(rd_col), out_valid <= 1, rd_col++.
  - Load of the window at rd_col = IMG_W-3 (the last window, IMG_W-2 windows per row) triggers retire, same cycle:
    - state -> IDLE, rd_col -> 0.
    - rd_sel increments mod 4.
    - pix_count -= IMG_W.
    - intr <= 1 for exactly one cycle.
  - IDLE may re-enter READ on the next cycle if the threshold still holds.
- Output register:
  - out_valid clears on a transfer with no new load in the same cycle.
  - While out_valid && !out_ready, out_window is held stable.
  - Latency: the window is visible one clock after the load condition.
- Window packing (left pixel at MSB of each 24-bit group), with lines L0=rd_sel, L1=rd_sel+1, L2=rd_sel+2 (mod 4) and columns c=rd_col:
  - [71:48] = {L0[c], L0[c+1], L0[c+2]}
  - [47:24] = the same three columns of L1
  - [23:0] = the same three columns of L2
- Line memory reads are asynchronous (combinational index). The writer can never overwrite a line being read, because that line still counts in pix_count until it is retired.
- Reset mid-operation: partial rows and any pending window are discarded. The first window after reset requires a fresh 3*IMG_W pixels.

Optional Feature:
- WINDOW_LAST_EN defined: adds output port out_last (1 bit).
  - Registered alongside out_window. It is 1 with the final window of each row (rd_col = IMG_W-3 load) and 0 otherwise.
  - Held stable under backpressure.
  - Reset value 0.
- WINDOW_LAST_EN undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Flat rows: reset, stream 384 pixels with row k all = k+1, out_ready=1.
  - out_valid rises 2 cycles after the 384th write.
  - 126 consecutive windows = 0x010101_020202_030303.
  - One intr pulse, coincident with the cycle after the last load.
- Column ramp: pixel = column index, 3 rows.
  - First window top group = 0x000102.
  - 126th window each group = 0x7D7E7F.
- Backpressure: drop out_ready for 5 cycles mid-row.
  - out_window/out_valid stable throughout.
  - Exactly 126 windows total, no duplicates or skips.
- Full: out_ready=0, stream 520 pixels.
  - in_ready falls after the 512th accepted write; pixels 513-520 are dropped.
  - Raise out_ready: after the row retires, in_ready=1 again and pix_count=384.
- Wrap: stream 6 rows (row k = k+1) with out_ready=1.
  - 4 intr pulses.
  - 4th row output = 0x040404_050505_060606, confirming rd_sel wrap.
- Async reset: pull reset low at rd_col=50, between clock edges.
  - out_valid=0 and in_ready=1 immediately.
  - Restream 3 rows; first window correct.

Source files
------------

// File: rtl/window_controller_if.sv
// Pixel-in / window-out handshake bundle for window_controller.
// Defining WINDOW_LAST_EN adds out_last alongside out_window.
interface window_controller_if;
  logic [7:0]  in_data;
  logic        in_valid_data;
  logic        in_ready;
  logic [71:0] out_window;
  logic        out_valid;
  logic        out_ready;
  logic        intr;
`ifdef WINDOW_LAST_EN
  logic        out_last;
`endif

  // Environment side: drives pixels in and accepts windows out.
  modport master (
    output in_data,
    output in_valid_data,
    output out_ready,
    input  in_ready,
    input  out_window,
    input  out_valid,
    input  intr
`ifdef WINDOW_LAST_EN
    , input out_last
`endif
  );

  modport slave (
    input  in_data,
    input  in_valid_data,
    input  out_ready,
    output in_ready,
    output out_window,
    output out_valid,
    output intr
`ifdef WINDOW_LAST_EN
    , output out_last
`endif
  );
endinterface

// File: rtl/window_controller.sv
// Four-line round-robin buffer emitting 3x3 pixel windows over valid/ready.
// Optional WINDOW_LAST_EN adds out_last flagging the final window of each row.
module window_controller #(
  parameter int unsigned IMG_W = 128
) (
  input logic                clk,
  input logic                reset,
  window_controller_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(4 * IMG_W + 1);
  localparam int unsigned COL_W = $clog2(IMG_W);

  typedef enum logic [0:0] {StIdle, StRead} state_e;

  logic [7:0]       mem [4][IMG_W];
  state_e           state_q, state_d;
  logic [COL_W-1:0] wr_col_q, wr_col_d, rd_col_q, rd_col_d;
  logic [1:0]       wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] pix_count_q, pix_count_d;
  logic [71:0]      out_window_q, out_window_d, win;
  logic             out_valid_q, out_valid_d;
  logic             intr_q, intr_d;
  logic             wr_en, load, last_col, retire;
`ifdef WINDOW_LAST_EN
  logic             last_q, last_d;
`endif

  assign bus.in_ready = (pix_count_q != CNT_W'(4 * IMG_W));
  assign wr_en        = bus.in_valid_data && bus.in_ready;
  assign load         = (state_q == StRead) && (!out_valid_q || bus.out_ready);
  assign last_col     = (rd_col_q == COL_W'(IMG_W - 3));
  assign retire       = load && last_col;

  // Line memories are not reset; the pixel count gates what is considered valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_sel_q][wr_col_q] <= bus.in_data;
  end

  // Left pixel lands in the MSB byte of each 24-bit line group.
  always_comb begin
    win = '0;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 3; k++) begin
        win[71 - 24 * l - 8 * k -: 8] = mem[rd_sel_q + 2'(l)][rd_col_q + COL_W'(k)];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pix_count_q >= CNT_W'(3 * IMG_W)) state_d = StRead;
      StRead:  if (retire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_col_d     = wr_col_q;
    wr_sel_d     = wr_sel_q;
    rd_col_d     = rd_col_q;
    rd_sel_d     = rd_sel_q;
    out_window_d = out_window_q;
    out_valid_d  = out_valid_q;
    intr_d       = retire;
    pix_count_d  = pix_count_q + CNT_W'(wr_en) - (retire ? CNT_W'(IMG_W) : '0);
    if (wr_en) begin
      if (wr_col_q == COL_W'(IMG_W - 1)) begin
        wr_col_d = '0;
        wr_sel_d = wr_sel_q + 2'd1;
      end else begin
        wr_col_d = wr_col_q + COL_W'(1);
      end
    end
    if (load) begin
      out_window_d = win;
      out_valid_d  = 1'b1;
      rd_col_d     = rd_col_q + COL_W'(1);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    if (retire) begin
      rd_col_d = '0;
      rd_sel_d = rd_sel_q + 2'd1;
    end
  end

`ifdef WINDOW_LAST_EN
  assign last_d       = load ? last_col : last_q;
  assign bus.out_last = last_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wr_col_q     <= '0;
      wr_sel_q     <= '0;
      rd_col_q     <= '0;
      rd_sel_q     <= '0;
      pix_count_q  <= '0;
      out_window_q <= '0;
      out_valid_q  <= 1'b0;
      intr_q       <= 1'b0;
`ifdef WINDOW_LAST_EN
      last_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_col_q     <= wr_col_d;
      wr_sel_q     <= wr_sel_d;
      rd_col_q     <= rd_col_d;
      rd_sel_q     <= rd_sel_d;
      pix_count_q  <= pix_count_d;
      out_window_q <= out_window_d;
      out_valid_q  <= out_valid_d;
      intr_q       <= intr_d;
`ifdef WINDOW_LAST_EN
      last_q       <= last_d;
`endif
    end
  end

  assign bus.out_window = out_window_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.intr       = intr_q;
endmodule

// File: tb/tb_window_controller.sv
// Bench for window_controller: every accepted pixel is logged and expected windows
// are recomputed from that raster log by row/column arithmetic.
module tb_window_controller;
  localparam int W = 128;
  localparam int N = W - 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  window_controller_if bus();
  window_controller #(.IMG_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  px[$];
  logic [71:0] got[$];
  int          xfers = 0;
  int          intr_cnt = 0;
  bit          hold_prev = 0;
  bit          rand_ready = 0;
  logic [71:0] prev_win = '0;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Window idx counts transfers since reset; output row r uses raster rows r..r+2.
  function automatic logic [71:0] exp_win(input int idx);
    logic [71:0] w = '0;
    int row = idx / N;
    int col = idx % N;
    for (int l = 0; l < 3; l++)
      for (int k = 0; k < 3; k++)
        w[71 - 24 * l - 8 * k -: 8] = px[(row + l) * W + col + k];
    return w;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (hold_prev) begin
        chk("hold_valid", 72'(bus.out_valid), 72'd1);
        chk("hold_window", bus.out_window, prev_win);
      end
      if (bus.intr) begin
        intr_cnt++;
        chk("intr_position", 72'(xfers % N), 72'(N - 1));
      end
`ifdef WINDOW_LAST_EN
      if (bus.out_valid) chk("out_last", 72'(bus.out_last), 72'(xfers % N == N - 1));
`endif
      if (bus.out_valid && bus.out_ready) begin
        chk("data_avail", 72'(px.size() >= (xfers / N + 3) * W), 72'd1);
        chk("window", bus.out_window, exp_win(xfers));
        got.push_back(bus.out_window);
        xfers++;
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      prev_win  = bus.out_window;
    end
  end

  task automatic model_clear();
    px.delete();
    got.delete();
    xfers     = 0;
    intr_cnt  = 0;
    hold_prev = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid_data = 1'b0;
    bus.in_data       = '0;
    bus.out_ready     = 1'b1;
    rand_ready        = 0;
    #2 reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("rst_out_window", bus.out_window, 72'd0);
    chk("rst_intr", 72'(bus.intr), 72'd0);
    chk("rst_in_ready", 72'(bus.in_ready), 72'd1);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  // One offer cycle; in_ready is stable from just after an edge to the next edge.
  task automatic put(input logic [7:0] d, output bit acc);
    bus.in_data       = d;
    bus.in_valid_data = 1'b1;
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    acc = bus.in_ready;
    if (acc) px.push_back(d);
    @(posedge clk); #1;
    bus.in_valid_data = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input bit gaps);
    bit acc = 0;
    if (gaps && $urandom_range(0, 3) == 0) idle(1);
    for (int t = 0; t < 2000 && !acc; t++) put(d, acc);
    chk("send_accept", 72'(acc), 72'd1);
  endtask

  task automatic wait_xfers(input int n);
    int t = 0;
    while (xfers < n && t < 5000) begin
      idle(1);
      t++;
    end
    chk("xfer_count", 72'(xfers), 72'(n));
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int acc_n;
    int first_drop;
    bit seen;

    bus.in_data = '0; bus.in_valid_data = 1'b0; bus.out_ready = 1'b1;

    // Flat rows and first-window latency
    do_reset();
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) send(8'(r + 1), 0);
    chk("lat_0", 72'(bus.out_valid), 72'd0);
    @(posedge clk); #1;
    chk("lat_1", 72'(bus.out_valid), 72'd0);
    @(posedge clk); #1;
    chk("lat_2", 72'(bus.out_valid), 72'd1);
    chk("flat_window", bus.out_window, 72'h010101_020202_030303);
    repeat (N) @(posedge clk);
    #1;
    chk("flat_consecutive", 72'(xfers), 72'(N));
    chk("flat_drained", 72'(bus.out_valid), 72'd0);
    chk("flat_intr", 72'(intr_cnt), 72'd1);

    // Column ramp
    do_reset();
    for (int r = 0; r < 3; r++) for (int c = 0; c < W; c++) send(8'(c), 0);
    wait_xfers(N);
    chk("ramp_first_top", 72'(got[0][71:48]), 72'h000102);
    chk("ramp_last", got[N - 1], 72'h7D7E7F_7D7E7F_7D7E7F);

    // Backpressure mid-row
    do_reset();
    for (int i = 0; i < 3 * W; i++) send(8'($urandom), 0);
    wait_xfers(60);
    bus.out_ready = 1'b0;
    idle(5);
    chk("bp_valid", 72'(bus.out_valid), 72'd1);
    bus.out_ready = 1'b1;
    wait_xfers(N);
    idle(4);
    chk("bp_total", 72'(xfers), 72'(N));
    chk("bp_intr", 72'(intr_cnt), 72'd1);

    // Full buffer
    do_reset();
    bus.out_ready = 1'b0;
    acc_n = 0; first_drop = -1;
    for (int i = 0; i < 520; i++) begin
      put(8'($urandom), acc);
      acc_n += int'(acc);
      if (!acc && first_drop < 0) first_drop = i;
    end
    chk("full_accepted", 72'(acc_n), 72'd512);
    chk("full_first_drop", 72'(first_drop), 72'd512);
    chk("full_in_ready", 72'(bus.in_ready), 72'd0);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 1000 && !seen; t++) begin
      @(posedge clk); #1;
      seen = bus.intr;
    end
    chk("full_retire_seen", 72'(seen), 72'd1);
    chk("full_reopen", 72'(bus.in_ready), 72'd1);
    bus.out_ready = 1'b0;
    acc_n = 0;
    for (int i = 0; i < 130; i++) begin
      put(8'($urandom), acc);
      acc_n += int'(acc);
    end
    chk("full_refill", 72'(acc_n), 72'd128);
    bus.out_ready = 1'b1;
    wait_xfers(3 * N);
    idle(4);
    chk("full_intr", 72'(intr_cnt), 72'd3);
    chk("full_in_ready_end", 72'(bus.in_ready), 72'd1);

    // Line-select wrap
    do_reset();
    for (int r = 0; r < 6; r++) for (int c = 0; c < W; c++) send(8'(r + 1), 0);
    wait_xfers(4 * N);
    idle(4);
    chk("wrap_intr", 72'(intr_cnt), 72'd4);
    chk("wrap_row4", got[3 * N], 72'h040404_050505_060606);
    chk("wrap_drained", 72'(bus.out_valid), 72'd0);

    // Random data, input gaps and random backpressure
    do_reset();
    rand_ready = 1;
    for (int i = 0; i < 5 * W; i++) send(8'($urandom), 1);
    wait_xfers(3 * N);
    rand_ready = 0;
    bus.out_ready = 1'b1;
    idle(4);
    chk("rand_total", 72'(xfers), 72'(3 * N));
    chk("rand_intr", 72'(intr_cnt), 72'd3);

    // Asynchronous reset mid-row
    do_reset();
    for (int i = 0; i < 3 * W; i++) send(8'($urandom), 0);
    wait_xfers(49);
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("arst_in_ready", 72'(bus.in_ready), 72'd1);
    chk("arst_intr", 72'(bus.intr), 72'd0);
    model_clear();
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3 * W; i++) send(8'($urandom), 0);
    chk("arst_no_early", 72'(bus.out_valid), 72'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_first_valid", 72'(bus.out_valid), 72'd1);
    chk("arst_first_window", bus.out_window, exp_win(0));
    wait_xfers(N);
    idle(4);
    chk("arst_intr_cnt", 72'(intr_cnt), 72'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
